bcd_to_bin_seq: RTL and testbench
=================================

# bcd_to_bin_seq

Parametrised, sequential multi-digit BCD-to-binary converter. It accepts a packed word of NUM_DIGITS BCD digits over a valid/ready handshake and folds one digit per clock, most significant digit first, as acc = acc*10 + digit. It returns the binary result over a second valid/ready handshake. It sits between BCD-producing front ends (keypad, display, counter logic) and binary datapaths, and generalises the two-digit combinational conversion to N digits with flow control and error flagging.

## Interface
- NUM_DIGITS, 4: number of BCD digits per input word; minimum 1.
- BIN_W, 14: result width; must satisfy 2^BIN_W >= 10^NUM_DIGITS (for example 2 digits needs 7, 4 digits needs 14).
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  input word present.
- o_ready  output  1  converter can accept a word.
- i_bcd  input  4*NUM_DIGITS  packed BCD; digit k occupies bits [4k+3:4k]; digit NUM_DIGITS-1 is the most significant.
- o_valid  output  1  result present.
- i_ready  input  1  downstream accepts the result.
- o_bin  output  BIN_W  binary result.
- o_err  output  1  at least one input digit was greater than 9 (see Configuration).

## Operation
- FSM states:
  - IDLE: o_ready=1.
    - i_valid=1: capture i_bcd, clear acc, clear digit counter, go to CONV.
    - i_valid=0: stay in IDLE.
  - CONV: o_ready=0; one digit per edge.
    - Each edge: acc = acc*10 + digit[NUM_DIGITS-1-cnt], then cnt increments.
    - After the digit with cnt=NUM_DIGITS-1: go to DONE and load o_bin from acc.
  - DONE: o_valid=1; o_bin and o_err held stable.
    - i_ready=1: go to IDLE.
    - i_ready=0: stay in DONE.
- Handshakes:
  - Input transfer occurs only when i_valid && o_ready.
  - Output transfer occurs only when o_valid && i_ready.
  - i_valid is ignored outside IDLE; the upstream must hold its word until it sees o_ready.
- Arithmetic:
  - acc*10 is computed as (acc<<3)+(acc<<1), in BIN_W+4 internal bits.
  - o_bin is the truncation to BIN_W bits. This is exact for legal input, and the value modulo 2^BIN_W for illegal input.
- o_err is cleared on input capture. It is set for the conversion if any digit is greater than 9. It is valid together with o_valid.
- Reset, asserted at any time including mid-conversion:
  - State goes to IDLE and any in-flight word is discarded.
  - Outputs: o_ready=1, o_valid=0, o_bin=0, o_err=0.
  - acc and cnt are cleared.

## Timing
- Latency:
  - An input accepted at edge T produces o_valid=1 after edge T+NUM_DIGITS.
  - With i_ready held high, o_ready returns to 1 after edge T+NUM_DIGITS+1.
- Throughput: one word per NUM_DIGITS+2 cycles when there is no backpressure.
- The block never accepts a new word in the same cycle as an output transfer.
- o_bin and o_err change only on entry to DONE, on reset, or on the capture edge (o_err clears there); o_bin is otherwise held.
- All outputs are registered; there is no combinational path from an input to an output.

## Configuration
- BCD2BIN_DIGIT_CHECK_EN:
  - Defined: per-digit range check is compiled in, and o_err behaves as specified above.
  - Undefined: checker logic is removed, and o_err is tied to 0. Illegal digits still fold arithmetically, modulo 2^BIN_W.

## Structure
- Package bcd_pkg holds:
  - the state enum (IDLE, CONV, DONE);
  - localparam DIGIT_W=4;
  - localparam MAX_DIGIT=4'd9.
- One sub-module, bcd_digit_mac: combinational acc*10+digit at width BIN_W+4, instantiated once in the datapath.
- The digit counter is $clog2(NUM_DIGITS)+1 bits wide.

## Test plan
- NUM_DIGITS=4, i_bcd=16'h1234, i_ready=1 → o_valid 4 cycles after accept, o_bin=14'd1234 (0x4D2), o_err=0.
- i_bcd=16'h9999 → o_bin=9999 (0x270F); i_bcd=16'h0000 → o_bin=0; back-to-back words → o_ready low for exactly 5 cycles per word.
- Macro defined, i_bcd=16'h12A4 → o_err=1 with o_valid; next legal word → o_err=0. Macro undefined, same input → o_err=0.
- Hold i_ready=0 for 6 cycles in DONE while pulsing i_valid with a different word → o_bin and o_valid stable, o_ready=0, the new word is not captured.
- Assert i_rst_n=0 mid-CONV (after 2 digits) → immediately o_valid=0, o_bin=0, o_ready=1. After release, a word 16'h0042 → o_bin=42.
- NUM_DIGITS=2, BIN_W=7, i_bcd=8'h59 → o_bin=7'd59 (0x3B) after 2 cycles.

Source files
------------

// File: rtl/bcd_to_bin_seq_pkg.sv
// bcd_pkg: shared types and constants for the sequential BCD-to-binary converter.
//   state_t      - controller states (IDLE, CONV, DONE)
//   DIGIT_W      - bits per BCD digit
//   MAX_DIGIT    - largest legal BCD digit value
//   is_bad_digit - true when a nibble is not a legal BCD digit
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int unsigned DIGIT_W   = 4;
  localparam logic [3:0]  MAX_DIGIT = 4'd9;

  function automatic logic is_bad_digit(input logic [DIGIT_W-1:0] d);
    return (d > MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: input and output valid/ready channels of the converter.
// Signal names are from the converter's point of view.
//   i_valid/o_ready/i_bcd - input word handshake (packed BCD, MS digit on top)
//   o_valid/i_ready/o_bin - result handshake
//   o_err                 - illegal-digit flag, qualified by o_valid
// Modports: slave = converter, master = upstream/downstream environment.
interface bcd_to_bin_seq_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
);
  logic                                 i_valid;
  logic                                 o_ready;
  logic [bcd_pkg::DIGIT_W*NUM_DIGITS-1:0] i_bcd;
  logic                                 o_valid;
  logic                                 i_ready;
  logic [BIN_W-1:0]                     o_bin;
  logic                                 o_err;

  modport slave (
    input  i_valid, i_bcd, i_ready,
    output o_ready, o_valid, o_bin, o_err
  );

  modport master (
    output i_valid, i_bcd, i_ready,
    input  o_ready, o_valid, o_bin, o_err
  );
endinterface

// File: rtl/bcd_digit_mac.sv
// bcd_digit_mac: combinational fold step o_acc = i_acc*10 + i_digit.
//   i_acc   - running accumulator (ACC_W bits)
//   i_digit - next BCD digit (not range-checked here)
//   o_acc   - result truncated to ACC_W bits
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic [ACC_W-1:0]   i_acc,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [ACC_W-1:0]   o_acc
);
  // x10 as shift-and-add: 8x + 2x
  always_comb begin
    o_acc = (i_acc << 3) + (i_acc << 1) + ACC_W'(i_digit);
  end
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential N-digit BCD-to-binary converter. Accepts a packed
// BCD word, folds one digit per clock (MS digit first) as acc = acc*10 + digit,
// then presents the binary result until the downstream takes it.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   bus     - bcd_to_bin_seq_if.slave (input word and result handshakes)
// Build option: define BCD2BIN_DIGIT_CHECK_EN to compile in the per-digit range
// check driving o_err; otherwise o_err is constant 0.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  bcd_to_bin_seq_if.slave bus
);
  localparam int unsigned ACC_W  = BIN_W + 4;
  localparam int unsigned CNT_W  = $clog2(NUM_DIGITS) + 1;
  localparam int unsigned WORD_W = DIGIT_W * NUM_DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  state_t             r_state;
  logic [WORD_W-1:0]  r_word;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;
  logic               r_valid;
  logic [BIN_W-1:0]   r_bin;

  logic [DIGIT_W-1:0] w_digit;
  logic [ACC_W-1:0]   w_mac;

  // The captured word is shifted left one digit per fold, so the top nibble is
  // always digit[NUM_DIGITS-1-cnt]; this avoids a variable-index mux.
  assign w_digit = r_word[WORD_W-1 -: DIGIT_W];

  bcd_digit_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .i_acc   (r_acc),
    .i_digit (w_digit),
    .o_acc   (w_mac)
  );

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic r_err;
  logic r_err_acc;
  logic w_bad;

  assign w_bad = is_bad_digit(w_digit);

  // Error is gathered during CONV and only published on entry to DONE so that
  // o_err moves together with o_bin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err     <= 1'b0;
      r_err_acc <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_valid) begin
            r_err     <= 1'b0;
            r_err_acc <= 1'b0;
          end
        end
        CONV: begin
          r_err_acc <= r_err_acc | w_bad;
          if (r_cnt == LAST_CNT) begin
            r_err <= r_err_acc | w_bad;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_err = r_err;
`else
  assign bus.o_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_bin   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_valid) begin
            r_word  <= bus.i_bcd;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_acc  <= w_mac;
          r_word <= r_word << DIGIT_W;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_bin   <= w_mac[BIN_W-1:0];
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready = r_ready;
  assign bus.o_valid = r_valid;
  assign bus.o_bin   = r_bin;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Testbench for bcd_to_bin_seq: scoreboard of expected results fed by the
// driver, checked by an independent monitor; plus a small 2-digit instance.
module tb_bcd_to_bin_seq;
  localparam int ND = 4;
  localparam int BW = 14;
  localparam int WW = 4 * ND;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;   // 0: i_ready=1, 1: i_ready=0, 2: random

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_to_bin_seq_if #(.NUM_DIGITS(ND), .BIN_W(BW)) u_if ();
  bcd_to_bin_seq_if #(.NUM_DIGITS(2), .BIN_W(7))   u_if2 ();

  bcd_to_bin_seq #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if)
  );

  bcd_to_bin_seq #(.NUM_DIGITS(2), .BIN_W(7)) dut2 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if2)
  );

  typedef struct {
    logic [BW-1:0] bin;
    logic          err;
    int            acc_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: positional value sum(d_k * 10^k), reduced modulo 2^BW.
  function automatic exp_t model(input logic [WW-1:0] w);
    exp_t   e;
    longint v = 0;
    longint p = 1;
    logic [3:0] d;
    e.err = 1'b0;
    for (int k = 0; k < ND; k++) begin
      d = w[4*k +: 4];
      v += longint'(d) * p;
      p *= 10;
      if (d > 4'd9) e.err = 1'b1;
    end
`ifndef BCD2BIN_DIGIT_CHECK_EN
    e.err = 1'b0;
`endif
    e.bin = BW'(v);
    e.acc_cyc = 0;
    return e;
  endfunction

  // i_ready generator
  initial begin
    u_if.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: u_if.i_ready = 1'b1;
        1: u_if.i_ready = 1'b0;
        default: u_if.i_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: latency, hold-while-stalled, result compare on output transfer
  initial begin
    logic          prev_v;
    logic [BW-1:0] prev_bin;
    logic          prev_err;
    exp_t          e;
    prev_v = 1'b0;
    prev_bin = '0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        continue;
      end
      if (u_if.o_valid) begin
        if (!prev_v) begin
          if (sb.size() == 0) chk("unexpected_valid", 1, 0);
          else chk("latency", cyc, sb[0].acc_cyc + ND);
        end else begin
          chk("bin_hold", u_if.o_bin, prev_bin);
          chk("err_hold", u_if.o_err, prev_err);
        end
        chk("ready_in_done", u_if.o_ready, 0);
        if (u_if.i_ready && sb.size() != 0) begin
          e = sb.pop_front();
          chk("o_bin", u_if.o_bin, e.bin);
          chk("o_err", u_if.o_err, e.err);
        end
      end
      prev_v   = u_if.o_valid;
      prev_bin = u_if.o_bin;
      prev_err = u_if.o_err;
    end
  end

  // Issue one word; returns at accept edge + #1 with i_valid dropped.
  task automatic send(input logic [WW-1:0] w, input bit chk_low);
    exp_t e;
    int   n;
    u_if.i_bcd   = w;
    u_if.i_valid = 1'b1;
    n = 0;
    while (!u_if.o_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout", n, 0);
      u_if.i_valid = 1'b0;
      return;
    end
    e = model(w);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    u_if.i_valid = 1'b0;
    u_if.i_bcd   = $urandom();
    if (chk_low) begin
      n = 0;
      while (!u_if.o_ready && n < 50) begin
        n++;
        @(posedge clk);
        #1;
      end
      chk("ready_low_cycles", n, ND + 1);
    end
  endtask

  initial begin
    logic [WW-1:0] w;
    int n;
    u_if.i_valid  = 1'b0;
    u_if.i_bcd    = '0;
    u_if2.i_valid = 1'b0;
    u_if2.i_bcd   = '0;
    u_if2.i_ready = 1'b1;

    #12;
    chk("rst_ready", u_if.o_ready, 1);
    chk("rst_valid", u_if.o_valid, 0);
    chk("rst_bin", u_if.o_bin, 0);
    chk("rst_err", u_if.o_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two-digit instance
    @(posedge clk);
    #1;
    u_if2.i_bcd   = 8'h59;
    u_if2.i_valid = 1'b1;
    @(posedge clk);
    #1;
    u_if2.i_valid = 1'b0;
    chk("nd2_valid_early", u_if2.o_valid, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("nd2_valid", u_if2.o_valid, 1);
    chk("nd2_bin", u_if2.o_bin, 59);
    chk("nd2_err", u_if2.o_err, 0);
    @(posedge clk);
    #1;
    chk("nd2_ready", u_if2.o_ready, 1);

    // Directed back-to-back words
    send(16'h1234, 1'b1);
    send(16'h9999, 1'b1);
    send(16'h0000, 1'b1);
    send(16'h12A4, 1'b1);
    send(16'h5555, 1'b1);

    // Backpressure: stall in DONE and offer a different word
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send(16'h0871, 1'b0);
    n = 0;
    while (!u_if.o_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_reach_done", u_if.o_valid, 1);
    for (int i = 0; i < 6; i++) begin
      u_if.i_valid = i[0] ? 1'b0 : 1'b1;
      u_if.i_bcd   = 16'h7777;
      @(posedge clk);
      #1;
      chk("bp_ready_low", u_if.o_ready, 0);
      chk("bp_valid_held", u_if.o_valid, 1);
    end
    u_if.i_valid = 1'b0;
    rdy_mode = 0;
    n = 0;
    while (!u_if.o_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end

    // Reset after two digits have been folded
    send(16'h5678, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", u_if.o_valid, 0);
    chk("midrst_bin", u_if.o_bin, 0);
    chk("midrst_ready", u_if.o_ready, 1);
    chk("midrst_err", u_if.o_err, 0);
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(16'h0042, 1'b1);

    // Random words with occasional illegal digits and random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < ND; k++) begin
        if ($urandom_range(0, 9) == 0) w[4*k +: 4] = 4'($urandom_range(10, 15));
        else w[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      send(w, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;

    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
